// File: rtl/spi_adc_multich_if.sv
// Pin-side and stream-side signals of the multichannel SPI ADC reader.
// slave is the reader itself; master is whatever drives sample/MISO and consumes frames.
interface spi_adc_multich_if #(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
);
  logic                            sample;
  logic [N_CH-1:0]                 MISO;
  logic                            CS_b;
  logic                            sclk;
  logic [N_CH*DATA_W-1:0]          out_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [$clog2(FIFO_DEPTH):0]     fifo_level;
  logic                            busy;
  logic                            overrun;
  logic                            dropped;
  logic                            flag_clr;

  modport slave (
    input  sample, MISO, out_ready, flag_clr,
    output CS_b, sclk, out_data, out_valid, fifo_level, busy, overrun, dropped
  );

  modport master (
    output sample, MISO, out_ready, flag_clr,
    input  CS_b, sclk, out_data, out_valid, fifo_level, busy, overrun, dropped
  );
endinterface

// File: rtl/spi_adc_multich.sv
// Reads N_CH SPI ADCs in lockstep on a shared CS_b/sclk and queues whole frames in a ready/valid FIFO.
// Frame takes 2*HALF*DATA_W cycles; a full FIFO drops the new frame unless a pop happens the same cycle.
module spi_adc_multich #(
  parameter int DATA_W      = 16,
  parameter int N_CH        = 2,
  parameter int LOG_CLK_DIV = 6,
  parameter int FIFO_DEPTH  = 4,
  parameter bit MSB_FIRST   = 1'b1
) (
  input logic             sysclk,
  input logic             reset,
  spi_adc_multich_if.slave bus
);

  localparam int CNT_W   = $clog2(DATA_W + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int FRAME_W = N_CH * DATA_W;
  localparam logic [LOG_CLK_DIV-1:0] DIV_INIT = LOG_CLK_DIV'(1) << (LOG_CLK_DIV - 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                 r_state;
  logic [LOG_CLK_DIV-1:0] r_div;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic [DATA_W-1:0]      r_sh [N_CH];
  logic                   r_cs_b;
  logic                   r_busy;
  logic                   r_overrun;
  logic                   r_dropped;
  logic [FRAME_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [LVL_W-1:0]       r_level;

  logic [LOG_CLK_DIV-1:0] w_div_nxt;
  logic                   w_fall;
  logic                   w_done;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic [FRAME_W-1:0]     w_frame;

  assign w_div_nxt = r_div + 1'b1;
  // sclk is the divider MSB, so its falling edge is the MSB going 1 -> 0.
  assign w_fall = (r_state == S_SHIFT) && r_div[LOG_CLK_DIV-1] && !w_div_nxt[LOG_CLK_DIV-1];
  assign w_done = (r_state == S_SHIFT) && (r_bit_cnt == CNT_W'(DATA_W)) && (w_div_nxt == DIV_INIT);
  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_pop  = (r_level != '0) && bus.out_ready;
  assign w_push = w_done && (!w_full || w_pop);

  always_comb begin
    w_frame = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_frame[c*DATA_W +: DATA_W] = r_sh[c];
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div     <= DIV_INIT;
      r_bit_cnt <= '0;
      r_cs_b    <= 1'b1;
      r_busy    <= 1'b0;
      for (int c = 0; c < N_CH; c++) r_sh[c] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_div <= DIV_INIT;
          if (bus.sample) begin
            r_state   <= S_SHIFT;
            r_cs_b    <= 1'b0;
            r_busy    <= 1'b1;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          r_div <= w_div_nxt;
          if (w_fall) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            for (int c = 0; c < N_CH; c++) begin
              if (MSB_FIRST) r_sh[c] <= {r_sh[c][DATA_W-2:0], bus.MISO[c]};
              else           r_sh[c] <= {bus.MISO[c], r_sh[c][DATA_W-1:1]};
            end
          end
          if (w_done) begin
            r_state <= S_IDLE;
            r_cs_b  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Clear wins over a coincident set.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_overrun <= 1'b0;
      r_dropped <= 1'b0;
    end else if (bus.flag_clr) begin
      r_overrun <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      if (bus.sample && (r_state == S_SHIFT)) r_overrun <= 1'b1;
      if (w_done && !w_push)                  r_dropped <= 1'b1;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_frame;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.CS_b       = r_cs_b;
  assign bus.sclk       = r_div[LOG_CLK_DIV-1];
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;
  assign bus.dropped    = r_dropped;
  assign bus.out_data   = r_mem[r_rd_ptr];
  assign bus.out_valid  = (r_level != '0);
  assign bus.fifo_level = r_level;

endmodule

// File: tb/tb_spi_adc_multich.sv
// Bench for spi_adc_multich: a default instance (16-bit, HALF=32, MSB first) and a fast
// instance (8-bit, HALF=1, LSB first), each fed by a serial ADC model and a frame queue.
module tb_spi_adc_multich;

  logic        sysclk;
  logic        reset;
  int          checks;
  int          errors;
  logic [31:0] cur_a;
  logic [15:0] cur_b;
  logic [31:0] exp_q[$];

  spi_adc_multich_if #(.N_CH(2), .DATA_W(16), .FIFO_DEPTH(4)) if_a();
  spi_adc_multich_if #(.N_CH(2), .DATA_W(8),  .FIFO_DEPTH(4)) if_b();

  spi_adc_multich #(.DATA_W(16), .N_CH(2), .LOG_CLK_DIV(6), .FIFO_DEPTH(4), .MSB_FIRST(1'b1))
    u_a (.sysclk(sysclk), .reset(reset), .bus(if_a));
  spi_adc_multich #(.DATA_W(8), .N_CH(2), .LOG_CLK_DIV(1), .FIFO_DEPTH(4), .MSB_FIRST(1'b0))
    u_b (.sysclk(sysclk), .reset(reset), .bus(if_b));

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ADC models: present bit idx of the current word, advancing after every sclk fall.
  initial begin : drv_a
    int   idx;
    logic prev;
    idx = 0;
    prev = 1'b1;
    forever begin
      @(negedge sysclk);
      if (if_a.CS_b === 1'b1) idx = 0;
      else if (prev === 1'b1 && if_a.sclk === 1'b0) idx++;
      prev = if_a.sclk;
      for (int c = 0; c < 2; c++)
        if_a.MISO[c] = (idx < 16) ? cur_a[c*16 + 15 - idx] : 1'b0;
    end
  end

  initial begin : drv_b
    int   idx;
    logic prev;
    idx = 0;
    prev = 1'b1;
    forever begin
      @(negedge sysclk);
      if (if_b.CS_b === 1'b1) idx = 0;
      else if (prev === 1'b1 && if_b.sclk === 1'b0) idx++;
      prev = if_b.sclk;
      for (int c = 0; c < 2; c++)
        if_b.MISO[c] = (idx < 8) ? cur_b[c*8 + idx] : 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic pop_a();
    if_a.out_ready = 1'b1;
    tick(1);
    if_a.out_ready = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    while (if_a.CS_b === 1'b0 && n < 3000) begin
      tick(1);
      n++;
    end
  endtask

  // Issues one sample and follows the frame until CS_b rises; optionally pulses
  // out_ready on the completion cycle.
  task automatic run_frame_a(input logic [31:0] w, input bit rdy_last,
                             output int low, output int falls, output int first, output int period);
    logic prev;
    cur_a = w;
    if_a.sample = 1'b1;
    tick(1);
    if_a.sample = 1'b0;
    low = 0; falls = 0; first = -1; period = -1; prev = 1'b1;
    while (if_a.CS_b === 1'b0 && low < 3000) begin
      if (prev === 1'b1 && if_a.sclk === 1'b0) begin
        falls++;
        if (first < 0) first = low;
        else if (period < 0) period = low - first;
      end
      prev = if_a.sclk;
      if (rdy_last && low == 1023) if_a.out_ready = 1'b1;
      low++;
      tick(1);
      if (rdy_last) if_a.out_ready = 1'b0;
    end
  endtask

  task automatic run_frame_b(input logic [15:0] w,
                             output int low, output int falls, output int first, output int period);
    logic prev;
    cur_b = w;
    if_b.sample = 1'b1;
    tick(1);
    if_b.sample = 1'b0;
    low = 0; falls = 0; first = -1; period = -1; prev = 1'b1;
    while (if_b.CS_b === 1'b0 && low < 200) begin
      if (prev === 1'b1 && if_b.sclk === 1'b0) begin
        falls++;
        if (first < 0) first = low;
        else if (period < 0) period = low - first;
      end
      prev = if_b.sclk;
      low++;
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    checks++; if (if_a.CS_b !== 1'b1) begin errors++; $display("FAIL reset_cs_b got %b want 1", if_a.CS_b); end
    checks++; if (if_a.sclk !== 1'b1) begin errors++; $display("FAIL reset_sclk got %b want 1", if_a.sclk); end
    checks++; if (if_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", if_a.busy); end
    checks++; if ({if_a.overrun, if_a.dropped} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b want 00", {if_a.overrun, if_a.dropped}); end
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_a.out_valid); end
    checks++; if (if_a.fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", if_a.fifo_level); end
    checks++; if (if_a.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", if_a.out_data); end
    checks++; if ({if_b.CS_b, if_b.sclk, if_b.out_valid} !== 3'b110) begin errors++; $display("FAIL reset_b got %b want 110", {if_b.CS_b, if_b.sclk, if_b.out_valid}); end
    reset = 1'b0;
    tick(4);
    checks++; if ({if_a.CS_b, if_a.sclk} !== 2'b11) begin errors++; $display("FAIL idle_pins got %b want 11", {if_a.CS_b, if_a.sclk}); end
  endtask

  task automatic test_basic();
    int low, falls, first, period;
    run_frame_a(32'h1234_A5C3, 1'b0, low, falls, first, period);
    checks++; if (low != 1024) begin errors++; $display("FAIL basic_cs_low got %0d want 1024", low); end
    checks++; if (falls != 16) begin errors++; $display("FAIL basic_falls got %0d want 16", falls); end
    checks++; if (first != 32) begin errors++; $display("FAIL basic_first_fall got %0d want 32", first); end
    checks++; if (period != 64) begin errors++; $display("FAIL basic_sclk_period got %0d want 64", period); end
    checks++; if (if_a.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", if_a.out_valid); end
    checks++; if (if_a.out_data !== 32'h1234_A5C3) begin errors++; $display("FAIL basic_data got %h want 1234a5c3", if_a.out_data); end
    checks++; if (if_a.fifo_level !== 3'd1) begin errors++; $display("FAIL basic_level got %0d want 1", if_a.fifo_level); end
    checks++; if ({if_a.busy, if_a.sclk} !== 2'b01) begin errors++; $display("FAIL basic_idle got %b want 01", {if_a.busy, if_a.sclk}); end
    pop_a();
    checks++; if ({if_a.out_valid, if_a.fifo_level} !== 4'b0000) begin errors++; $display("FAIL basic_pop got %b want 0000", {if_a.out_valid, if_a.fifo_level}); end
  endtask

  task automatic test_back_to_back();
    int low, falls, first, period;
    logic [31:0] w;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      run_frame_a(w, 1'b0, low, falls, first, period);
      exp_q.push_back(w);
      checks++; if (low != 1024) begin errors++; $display("FAIL b2b_cs_low[%0d] got %0d want 1024", i, low); end
      checks++; if (if_a.fifo_level !== 3'(exp_q.size())) begin errors++; $display("FAIL b2b_level[%0d] got %0d want %0d", i, if_a.fifo_level, exp_q.size()); end
    end
    while (exp_q.size() > 0) begin
      checks++; if (if_a.out_data !== exp_q[0]) begin errors++; $display("FAIL b2b_data got %h want %h", if_a.out_data, exp_q[0]); end
      pop_a();
      void'(exp_q.pop_front());
    end
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", if_a.out_valid); end
  endtask

  task automatic test_bitorder();
    int low, falls, first, period;
    logic [15:0] w;
    w = {8'($urandom), 8'h01};
    run_frame_b(w, low, falls, first, period);
    checks++; if (low != 16) begin errors++; $display("FAIL lsb_cs_low got %0d want 16", low); end
    checks++; if (falls != 8) begin errors++; $display("FAIL lsb_falls got %0d want 8", falls); end
    checks++; if (first != 1 || period != 2) begin errors++; $display("FAIL lsb_sclk got first %0d period %0d want 1 2", first, period); end
    checks++; if (if_b.out_data[7:0] !== 8'h01) begin errors++; $display("FAIL lsb_ch0 got %h want 01", if_b.out_data[7:0]); end
    checks++; if (if_b.out_data !== w) begin errors++; $display("FAIL lsb_frame got %h want %h", if_b.out_data, w); end
    w = 16'($urandom);
    run_frame_b(w, low, falls, first, period);
    checks++; if (if_b.fifo_level !== 3'd2) begin errors++; $display("FAIL lsb_level got %0d want 2", if_b.fifo_level); end
    if_b.out_ready = 1'b1;
    tick(1);
    if_b.out_ready = 1'b0;
    checks++; if (if_b.out_data !== w) begin errors++; $display("FAIL lsb_frame2 got %h want %h", if_b.out_data, w); end
  endtask

  task automatic test_overrun();
    logic [31:0] w, w2;
    w = $urandom;
    cur_a = w;
    if_a.sample = 1'b1; tick(1); if_a.sample = 1'b0;
    tick(499);
    if_a.sample = 1'b1; tick(1); if_a.sample = 1'b0;
    checks++; if ({if_a.overrun, if_a.busy} !== 2'b11) begin errors++; $display("FAIL ovr_set got %b want 11", {if_a.overrun, if_a.busy}); end
    tick(523);
    checks++; if ({if_a.CS_b, if_a.overrun} !== 2'b01) begin errors++; $display("FAIL ovr_last_cycle got %b want 01", {if_a.CS_b, if_a.overrun}); end
    // Sample on the completion cycle is ignored; the coincident clear wins.
    if_a.sample = 1'b1; if_a.flag_clr = 1'b1; tick(1); if_a.sample = 1'b0; if_a.flag_clr = 1'b0;
    checks++; if ({if_a.CS_b, if_a.overrun} !== 2'b10) begin errors++; $display("FAIL ovr_clr_prio got %b want 10", {if_a.CS_b, if_a.overrun}); end
    tick(3);
    checks++; if (if_a.CS_b !== 1'b1 || if_a.fifo_level !== 3'd1) begin errors++; $display("FAIL ovr_one_frame got cs %b level %0d want 1 1", if_a.CS_b, if_a.fifo_level); end
    w2 = $urandom;
    cur_a = w2;
    if_a.sample = 1'b1; tick(1); if_a.sample = 1'b0;
    tick(9);
    if_a.sample = 1'b1; tick(1);
    checks++; if (if_a.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set2 got %b want 1", if_a.overrun); end
    if_a.flag_clr = 1'b1; tick(1); if_a.flag_clr = 1'b0;
    checks++; if (if_a.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr_vs_set got %b want 0", if_a.overrun); end
    tick(1); if_a.sample = 1'b0;
    checks++; if (if_a.overrun !== 1'b1) begin errors++; $display("FAIL ovr_reset_again got %b want 1", if_a.overrun); end
    if_a.flag_clr = 1'b1; tick(1); if_a.flag_clr = 1'b0;
    checks++; if (if_a.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b want 0", if_a.overrun); end
    wait_idle_a();
    checks++; if (if_a.fifo_level !== 3'd2) begin errors++; $display("FAIL ovr_level got %0d want 2", if_a.fifo_level); end
    checks++; if (if_a.out_data !== w) begin errors++; $display("FAIL ovr_data1 got %h want %h", if_a.out_data, w); end
    pop_a();
    checks++; if (if_a.out_data !== w2) begin errors++; $display("FAIL ovr_data2 got %h want %h", if_a.out_data, w2); end
    pop_a();
  endtask

  task automatic test_fifo_full();
    int low, falls, first, period;
    logic [31:0] w, head;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      run_frame_a(w, 1'b0, low, falls, first, period);
      if (i < 4) exp_q.push_back(w);
      if (i == 3) begin
        checks++; if (if_a.dropped !== 1'b0) begin errors++; $display("FAIL full_no_drop_yet got %b want 0", if_a.dropped); end
      end
    end
    checks++; if (if_a.fifo_level !== 3'd4) begin errors++; $display("FAIL full_level got %0d want 4", if_a.fifo_level); end
    checks++; if (if_a.dropped !== 1'b1) begin errors++; $display("FAIL full_dropped got %b want 1", if_a.dropped); end
    head = exp_q[0];
    tick(5);
    checks++; if (if_a.out_data !== head) begin errors++; $display("FAIL full_hold got %h want %h", if_a.out_data, head); end
    if_a.flag_clr = 1'b1; tick(1); if_a.flag_clr = 1'b0;
    checks++; if (if_a.dropped !== 1'b0) begin errors++; $display("FAIL drop_clear got %b want 0", if_a.dropped); end
    w = $urandom;
    run_frame_a(w, 1'b1, low, falls, first, period);
    void'(exp_q.pop_front());
    exp_q.push_back(w);
    checks++; if (if_a.fifo_level !== 3'd4 || if_a.dropped !== 1'b0) begin errors++; $display("FAIL pushpop_full got level %0d dropped %b want 4 0", if_a.fifo_level, if_a.dropped); end
    while (exp_q.size() > 0) begin
      checks++; if (if_a.out_data !== exp_q[0]) begin errors++; $display("FAIL full_order got %h want %h", if_a.out_data, exp_q[0]); end
      pop_a();
      void'(exp_q.pop_front());
    end
    checks++; if ({if_a.out_valid, if_a.fifo_level} !== 4'b0000) begin errors++; $display("FAIL full_drained got %b want 0000", {if_a.out_valid, if_a.fifo_level}); end
  endtask

  task automatic test_reset_mid();
    int low, falls, first, period, lows;
    logic [31:0] w;
    run_frame_a(32'($urandom), 1'b0, low, falls, first, period);
    cur_a = $urandom;
    if_a.sample = 1'b1; tick(1); if_a.sample = 1'b0;
    tick(300);
    reset = 1'b1; tick(1); reset = 1'b0;
    checks++; if ({if_a.CS_b, if_a.sclk, if_a.busy} !== 3'b110) begin errors++; $display("FAIL rstmid_pins got %b want 110", {if_a.CS_b, if_a.sclk, if_a.busy}); end
    checks++; if ({if_a.out_valid, if_a.fifo_level} !== 4'b0000) begin errors++; $display("FAIL rstmid_fifo got %b want 0000", {if_a.out_valid, if_a.fifo_level}); end
    lows = 0;
    for (int i = 0; i < 1100; i++) begin
      if (if_a.CS_b !== 1'b1 || if_a.sclk !== 1'b1) lows++;
      tick(1);
    end
    checks++; if (lows != 0 || if_a.fifo_level !== 3'd0) begin errors++; $display("FAIL rstmid_quiet got %0d active %0d level want 0 0", lows, if_a.fifo_level); end
    w = $urandom;
    run_frame_a(w, 1'b0, low, falls, first, period);
    checks++; if (low != 1024 || falls != 16) begin errors++; $display("FAIL rstmid_clean got low %0d falls %0d want 1024 16", low, falls); end
    checks++; if (if_a.out_data !== w || if_a.fifo_level !== 3'd1) begin errors++; $display("FAIL rstmid_data got %h level %0d want %h 1", if_a.out_data, if_a.fifo_level, w); end
    pop_a();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    cur_a = '0;
    cur_b = '0;
    if_a.sample = 1'b0; if_a.out_ready = 1'b0; if_a.flag_clr = 1'b0;
    if_b.sample = 1'b0; if_b.out_ready = 1'b0; if_b.flag_clr = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_bitorder();
    test_overrun();
    test_fifo_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
